// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state/owner encodings
// and the default watchdog length.
package bus_arbiter_pkg;

    // State encodings double as the one-hot grant vector driven on grant_O.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_GNT_INST = 2'b01,
        ST_GNT_DATA = 2'b10
    } state_e;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Bus watchdog: emits a one-cycle pulse after TIMEOUT_CYCLES strobed cycles without ACK.
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic enable_i,
    input  logic ack_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int unsigned CW     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          ACTIVE = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_o = 1'b0;
        if (!ACTIVE || clear_i || ack_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            timeout_o = 1'b1;
            cnt_d     = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (fetch/data) to one-slave Wishbone arbiter with round-robin grants
// held for whole CYC cycles and a no-ACK watchdog.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned BYTE_AMNT      = 8,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter bit          ROUND_ROBIN    = 1'b1
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   inst_CYC_I,
    input  logic                   inst_STB_I,
    input  logic [8*BYTE_AMNT-1:0] inst_ADR_I,
    output logic [8*BYTE_AMNT-1:0] inst_DAT_O,
    output logic                   inst_ACK_O,
    output logic                   inst_ERR_O,
    input  logic                   data_CYC_I,
    input  logic                   data_STB_I,
    input  logic                   data_WE_I,
    input  logic [BYTE_AMNT-1:0]   data_SEL_I,
    input  logic [8*BYTE_AMNT-1:0] data_DAT_I,
    input  logic [8*BYTE_AMNT-1:0] data_ADR_I,
    output logic [8*BYTE_AMNT-1:0] data_DAT_O,
    output logic                   data_ACK_O,
    output logic                   data_ERR_O,
    output logic                   mem_CYC_O,
    output logic                   mem_STB_O,
    output logic                   mem_WE_O,
    output logic [BYTE_AMNT-1:0]   mem_SEL_O,
    output logic [8*BYTE_AMNT-1:0] mem_ADR_O,
    output logic [8*BYTE_AMNT-1:0] mem_DAT_O,
    input  logic [8*BYTE_AMNT-1:0] mem_DAT_I,
    input  logic                   mem_ACK_I,
    output logic [1:0]             grant_O
);

    state_e state_q, state_d;
    owner_e last_q, last_d;
    logic   wd_enable, wd_clear, wd_timeout;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            last_q  <= OWNER_DATA;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (inst_CYC_I && data_CYC_I)
                    state_d = (ROUND_ROBIN && last_q == OWNER_INST) ? ST_GNT_DATA : ST_GNT_INST;
                else if (inst_CYC_I)
                    state_d = ST_GNT_INST;
                else if (data_CYC_I)
                    state_d = ST_GNT_DATA;
            end
            ST_GNT_INST: begin
                if (!inst_CYC_I) begin
                    last_d  = OWNER_INST;
                    state_d = data_CYC_I ? ST_GNT_DATA : ST_IDLE;
                end
            end
            ST_GNT_DATA: begin
                if (!data_CYC_I) begin
                    last_d  = OWNER_DATA;
                    state_d = inst_CYC_I ? ST_GNT_INST : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_CYC_O   = 1'b0;
        mem_STB_O   = 1'b0;
        mem_WE_O    = 1'b0;
        mem_SEL_O   = '0;
        mem_ADR_O   = '0;
        mem_DAT_O   = '0;
        inst_ACK_O  = 1'b0;
        inst_ERR_O  = 1'b0;
        data_ACK_O  = 1'b0;
        data_ERR_O  = 1'b0;
        wd_enable   = 1'b0;
        unique case (state_q)
            ST_GNT_INST: begin
                mem_CYC_O  = inst_CYC_I;
                mem_STB_O  = inst_STB_I;
                mem_SEL_O  = '1;
                mem_ADR_O  = inst_ADR_I;
                inst_ACK_O = mem_ACK_I;
                inst_ERR_O = wd_timeout;
                wd_enable  = inst_STB_I;
            end
            ST_GNT_DATA: begin
                mem_CYC_O  = data_CYC_I;
                mem_STB_O  = data_STB_I;
                mem_WE_O   = data_WE_I;
                mem_SEL_O  = data_SEL_I;
                mem_ADR_O  = data_ADR_I;
                mem_DAT_O  = data_DAT_I;
                data_ACK_O = mem_ACK_I;
                data_ERR_O = wd_timeout;
                wd_enable  = data_STB_I;
            end
            default: ;
        endcase
    end

    assign inst_DAT_O = mem_DAT_I;
    assign data_DAT_O = mem_DAT_I;
    assign grant_O    = state_q;
    // Any grant change restarts the timeout window for the next owner.
    assign wd_clear   = (state_d != state_q);

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .enable_i (wd_enable),
        .ack_i    (mem_ACK_I),
        .clear_i  (wd_clear),
        .timeout_o(wd_timeout)
    );

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter between the hart's instruction-fetch port and data (load/store) port.
- Its single master-side output drives the memory controller's cpu_* interface.
- Grants are held for a whole CYC bus cycle and alternate round-robin under contention.
- A watchdog ends transactions that no slave acknowledges, for example accesses to unmapped addresses, where the controller never raises ACK.

Parameters:
- BYTE_AMNT, 8, bus width in bytes; data and address are 8*BYTE_AMNT bits.
- TIMEOUT_CYCLES, 1024, cycles with STB high and no ACK before an error is signalled; 0 disables the watchdog.
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority, with inst always winning.

Ports:
- CLK_I  in  1  system clock; all state changes on its rising edge.
- RST_I  in  1  asynchronous, active-high reset.
- inst_CYC_I  in  1  fetch bus cycle.
- inst_STB_I  in  1  fetch strobe.
- inst_ADR_I  in  8*BYTE_AMNT  fetch address.
- inst_DAT_O  out  8*BYTE_AMNT  fetch read data.
- inst_ACK_O  out  1  fetch acknowledge.
- inst_ERR_O  out  1  fetch timeout error.
- data_CYC_I  in  1  data bus cycle.
- data_STB_I  in  1  data strobe.
- data_WE_I  in  1  data write enable.
- data_SEL_I  in  BYTE_AMNT  byte lanes.
- data_DAT_I  in  8*BYTE_AMNT  write data.
- data_ADR_I  in  8*BYTE_AMNT  data address.
- data_DAT_O  out  8*BYTE_AMNT  read data.
- data_ACK_O  out  1  data acknowledge.
- data_ERR_O  out  1  data timeout error.
- mem_CYC_O  out  1  to memory controller cpu_CYC_I.
- mem_STB_O  out  1  to memory controller cpu_STB_I.
- mem_WE_O  out  1  to memory controller cpu_WE_I.
- mem_SEL_O  out  BYTE_AMNT  to memory controller cpu_SEL_I.
- mem_ADR_O  out  8*BYTE_AMNT  to memory controller cpu_ADR_I.
- mem_DAT_O  out  8*BYTE_AMNT  to memory controller cpu_DAT_I.
- mem_DAT_I  in  8*BYTE_AMNT  from memory controller cpu_DAT_O.
- mem_ACK_I  in  1  from memory controller cpu_ACK_O.
- grant_O  out  2  one-hot current owner: bit0 = inst, bit1 = data; 00 when idle.

Behaviour:
- Interface: one clock, CLK_I; reset RST_I is asynchronous and active-high. On reset the FSM goes to IDLE, last_owner = DATA (so inst wins the first tie), and the watchdog count = 0.
- Outputs while in reset or IDLE: all mem_* control outputs 0, mem_SEL_O = 0, mem_ADR_O/mem_DAT_O = 0, all ACK/ERR 0, grant_O = 00.
- FSM states: IDLE, GNT_INST, GNT_DATA; the state register is the only grant source.
- From IDLE:
  - Only inst_CYC_I high -> GNT_INST next edge.
  - Only data_CYC_I high -> GNT_DATA.
  - Both high -> the master other than last_owner when ROUND_ROBIN = 1, else inst.
  - Arbitration latency: 1 cycle from CYC high in IDLE to the grant.
- From GNT_X:
  - While X_CYC_I = 1, stay (no preemption).
  - When X_CYC_I = 0: if the other master's CYC is high, go directly to its grant with no idle cycle; otherwise go to IDLE. last_owner <= X on leaving.
- Datapath (combinational on state):
  - GNT_INST: mem_CYC/STB = inst_CYC/STB, mem_WE = 0, mem_SEL = all ones, mem_ADR = inst_ADR_I, mem_DAT_O = 0.
  - GNT_DATA: all signals pass through from data_*.
- Return path:
  - mem_DAT_I is broadcast to both X_DAT_O.
  - mem_ACK_I reaches only the granted master's ACK; the non-granted ACK and ERR are 0.
  - An ACK arriving while in IDLE is dropped.
- Watchdog:
  - Counts cycles where the granted master has STB = 1 and mem_ACK_I = 0.
  - It is cleared on ACK, on any state change, and when STB = 0.
  - When count == TIMEOUT_CYCLES-1 with no ACK, the granted X_ERR_O pulses for exactly 1 cycle and the count clears.
  - The FSM keeps the grant until the master drops CYC.
  - ACK and ERR are never asserted in the same cycle; ACK wins if it arrives on the timeout cycle.
- Reset asserted mid-transaction: outputs drop asynchronously to their reset values; no ACK/ERR is produced afterwards for that transaction.
- Count width: clog2(TIMEOUT_CYCLES+1) bits, saturating; no wrap.

Decomposition:
- Shared header:
  - state encodings (IDLE = 2'b00, GNT_INST = 2'b01, GNT_DATA = 2'b10, matching grant_O);
  - owner IDs;
  - default TIMEOUT_CYCLES.
- One sub-module, bus_watchdog: parameters TIMEOUT_CYCLES; inputs CLK_I, RST_I, enable (STB & granted), ack, clear (state change); output one-cycle timeout pulse.

Test Plan:
- Reset then inst_CYC/STB = 1 with ADR 0x0000_0100: cycle 1 grant_O = 01; mem_ADR_O = 0x100, mem_SEL_O = 0xFF, mem_WE_O = 0. The slave raises ACK with DAT 0xDEADBEEF -> inst_ACK_O = 1, inst_DAT_O = 0xDEADBEEF, data_ACK_O = 0.
- Both CYC rise together after reset -> inst is granted first. When inst drops CYC, the next cycle grant_O = 10 with no IDLE cycle. On the next simultaneous request from IDLE, inst is granted (last_owner = DATA); with ROUND_ROBIN = 0, inst is always granted.
- Data write, ADR 0x0100_0008, SEL 0x0F, DAT 0x1234, WE = 1 -> mem_* mirror these values. An inst request raised mid-cycle is ignored until data_CYC drops.
- TIMEOUT_CYCLES = 4, data STB to unmapped 0x2000_0000 with no ACK -> data_ERR_O high exactly on the 4th STB cycle, for 1 cycle. Holding STB longer repeats ERR every 4 cycles; inst_ERR_O stays 0.
- RST_I pulsed asynchronously mid-transfer while in GNT_DATA -> mem_CYC_O/STB_O fall immediately (no clock edge needed) and grant_O = 00. A late mem_ACK_I is not forwarded.
- TIMEOUT_CYCLES = 0, STB held 5000 cycles without ACK -> no ERR, and the grant is held.
